// File: rtl/channel_mixer_pkg.sv
// Shared constants and types for the channel mixer.
//   SAMPLE_WIDTH  : width of the mixed output words handed to the I2S serializer
//   NUM_CHANNELS  : maximum number of channel samples in one frame
//   MIX_ACC_WIDTH : accumulator width, SAMPLE_WIDTH + clog2(NUM_CHANNELS) rounded up
//   mixer_state_t : mixer frame-sequencing states
package channel_mixer_pkg;
  localparam int unsigned SAMPLE_WIDTH  = 16;
  localparam int unsigned NUM_CHANNELS  = 18;
  localparam int unsigned MIX_ACC_WIDTH = SAMPLE_WIDTH + 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT
  } mixer_state_t;
endpackage

// File: rtl/channel_mixer_sample_sat.sv
// Combinational clamp of a wide signed accumulator to a narrower signed word.
//   acc_i  : ACC_WIDTH signed accumulator value
//   sat_o  : OUT_WIDTH signed value clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
//   clip_o : high when clamping changed the value
module sample_sat #(
  parameter int unsigned ACC_WIDTH = 21,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [OUT_WIDTH-1:0] sat_o,
  output logic                 clip_o
);

  // The value fits when every bit from the output sign bit upward agrees.
  logic [ACC_WIDTH-OUT_WIDTH:0] top_bits;
  assign top_bits = acc_i[ACC_WIDTH-1:OUT_WIDTH-1];

  always_comb begin
    clip_o = !((&top_bits) || !(|top_bits));
    if (!clip_o) begin
      sat_o = acc_i[OUT_WIDTH-1:0];
    end else if (acc_i[ACC_WIDTH-1]) begin
      sat_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/channel_mixer.sv
// Sums a frame of routed signed channel samples into left/right words.
//   clk, reset_n    : system clock, asynchronous active-low reset
//   sample_clk_en   : one-cycle frame start strobe
//   ch_valid        : ch_sample/ch_left/ch_right/ch_last valid this cycle
//   ch_sample       : signed channel sample
//   ch_left/right   : routing bits for the sample
//   ch_last         : final sample of the frame
//   left_channel    : saturated left sum, held until the next publish
//   right_channel   : saturated right sum, held until the next publish
//   sample_valid    : one-cycle pulse when the words update
//   clip_left/right : pulse with sample_valid when that side saturated
//   frame_overrun   : one-cycle pulse when a new start abandons a frame
module channel_mixer #(
  parameter int unsigned NUM_CHANNELS = channel_mixer_pkg::NUM_CHANNELS,
  parameter int unsigned IN_WIDTH     = channel_mixer_pkg::SAMPLE_WIDTH,
  parameter int unsigned OUT_WIDTH    = channel_mixer_pkg::SAMPLE_WIDTH,
  parameter int unsigned ACC_WIDTH    = IN_WIDTH + 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_clk_en,
  input  logic                 ch_valid,
  input  logic [IN_WIDTH-1:0]  ch_sample,
  input  logic                 ch_left,
  input  logic                 ch_right,
  input  logic                 ch_last,
  output logic [OUT_WIDTH-1:0] left_channel,
  output logic [OUT_WIDTH-1:0] right_channel,
  output logic                 sample_valid,
  output logic                 clip_left,
  output logic                 clip_right,
  output logic                 frame_overrun
);
  import channel_mixer_pkg::*;

  localparam int unsigned CNT_W = $clog2(NUM_CHANNELS + 1);

  mixer_state_t state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, ch_ext;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] left_q, left_d, right_q, right_d, sat_l, sat_r;
  logic                 valid_q, clip_l_q, clip_l_d, clip_r_q, clip_r_d, ovr_q;
  logic                 sat_clip_l, sat_clip_r;
  logic                 frame_done, clr_acc, take, publish, overrun;

  assign ch_ext     = {{(ACC_WIDTH-IN_WIDTH){ch_sample[IN_WIDTH-1]}}, ch_sample};
  assign frame_done = ch_last || (cnt_q == CNT_W'(NUM_CHANNELS - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a start strobe always wins, so a start seen during SAT is
  // not lost and one seen during ACCUM restarts the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_clk_en) state_d = ACCUM;
      ACCUM:   if (!sample_clk_en && ch_valid && frame_done) state_d = SAT;
      SAT:     state_d = sample_clk_en ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    clr_acc = sample_clk_en;
    take    = (state_q == ACCUM) && ch_valid && !sample_clk_en;
    publish = (state_q == SAT);
    overrun = (state_q == ACCUM) && sample_clk_en;
  end

  // Datapath next-state
  always_comb begin
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    right_d  = right_q;
    clip_l_d = 1'b0;
    clip_r_d = 1'b0;
    if (clr_acc) begin
      acc_l_d = '0;
      acc_r_d = '0;
      cnt_d   = '0;
    end else if (take) begin
      if (ch_left)  acc_l_d = acc_l_q + ch_ext;
      if (ch_right) acc_r_d = acc_r_q + ch_ext;
      cnt_d = cnt_q + 1'b1;
    end
    if (publish) begin
      left_d   = sat_l;
      right_d  = sat_r;
      clip_l_d = sat_clip_l;
      clip_r_d = sat_clip_r;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= publish;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      ovr_q    <= overrun;
    end
  end

  sample_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat_left (
    .acc_i  (acc_l_q),
    .sat_o  (sat_l),
    .clip_o (sat_clip_l)
  );

  sample_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat_right (
    .acc_i  (acc_r_q),
    .sat_o  (sat_r),
    .clip_o (sat_clip_r)
  );

  assign left_channel  = left_q;
  assign right_channel = right_q;
  assign sample_valid  = valid_q;
  assign clip_left     = clip_l_q;
  assign clip_right    = clip_r_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_channel_mixer.sv
module tb_channel_mixer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_clk_en;
  logic        ch_valid;
  logic [15:0] ch_sample;
  logic        ch_left;
  logic        ch_right;
  logic        ch_last;
  logic [15:0] left_channel;
  logic [15:0] right_channel;
  logic        sample_valid;
  logic        clip_left;
  logic        clip_right;
  logic        frame_overrun;

  int n_chk = 0;
  int n_err = 0;
  int sv_cnt = 0;
  int prev_l = 0;
  int prev_r = 0;

  int smp [18];
  bit rl  [18];
  bit rr  [18];

  channel_mixer #(.NUM_CHANNELS(18), .IN_WIDTH(16), .OUT_WIDTH(16), .ACC_WIDTH(21)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_clk_en (sample_clk_en),
    .ch_valid      (ch_valid),
    .ch_sample     (ch_sample),
    .ch_left       (ch_left),
    .ch_right      (ch_right),
    .ch_last       (ch_last),
    .left_channel  (left_channel),
    .right_channel (right_channel),
    .sample_valid  (sample_valid),
    .clip_left     (clip_left),
    .clip_right    (clip_right),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sample_valid === 1'b1) sv_cnt++;

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    sample_clk_en = 1'b1;
    tick();
    sample_clk_en = 1'b0;
  endtask

  task automatic send(input int s, input bit l, input bit r, input bit last);
    ch_valid  = 1'b1;
    ch_sample = 16'(s);
    ch_left   = l;
    ch_right  = r;
    ch_last   = last;
    tick();
    ch_valid = 1'b0;
    ch_last  = 1'b0;
  endtask

  // Called just after the edge that accepted the final sample.
  task automatic expect_publish(input string tag, input int sl, input int sr);
    chk({tag, "_sv_early"}, sample_valid, 0);
    tick();
    chk({tag, "_sv"},    sample_valid, 1);
    chk({tag, "_left"},  $signed(left_channel), clamp16(sl));
    chk({tag, "_right"}, $signed(right_channel), clamp16(sr));
    chk({tag, "_clipL"}, clip_left, (sl != clamp16(sl)));
    chk({tag, "_clipR"}, clip_right, (sr != clamp16(sr)));
    tick();
    chk({tag, "_sv_end"}, sample_valid, 0);
    prev_l = clamp16(sl);
    prev_r = clamp16(sr);
  endtask

  // Sends smp/rl/rr[0..n-1] as one frame and checks the published result.
  task automatic run_frame(input string tag, input int n, input bit use_last, input bit gaps);
    int sl = 0;
    int sr = 0;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) tick();
      send(smp[i], rl[i], rr[i], use_last && (i == n - 1));
      if (rl[i]) sl += smp[i];
      if (rr[i]) sr += smp[i];
    end
    expect_publish(tag, sl, sr);
  endtask

  initial begin
    int base;
    int sl;
    int sr;
    reset_n       = 1'b0;
    sample_clk_en = 1'b0;
    ch_valid      = 1'b0;
    ch_sample     = '0;
    ch_left       = 1'b0;
    ch_right      = 1'b0;
    ch_last       = 1'b0;
    repeat (3) tick();
    chk("rst_left", left_channel, 0);
    chk("rst_right", right_channel, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_clipL", clip_left, 0);
    chk("rst_clipR", clip_right, 0);
    chk("rst_ovr", frame_overrun, 0);
    reset_n = 1'b1;
    tick();

    // Routing: all left, channels 0-8 also right
    for (int i = 0; i < 18; i++) begin
      smp[i] = 100; rl[i] = 1'b1; rr[i] = (i < 9);
    end
    base = sv_cnt;
    run_frame("route", 18, 1'b1, 1'b0);
    repeat (3) tick();
    chk("route_pulses", sv_cnt - base, 1);

    // Saturation
    for (int i = 0; i < 18; i++) begin smp[i] = 32767; rl[i] = 1'b1; rr[i] = 1'b1; end
    run_frame("satpos", 18, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) smp[i] = -32768;
    run_frame("satneg", 18, 1'b1, 1'b0);
    smp[0] = 30000; smp[1] = 30000; smp[2] = -30000;
    run_frame("nosat", 3, 1'b1, 1'b0);

    // Short frame, then a stray valid in IDLE
    smp[0] = 1000; smp[1] = -250; smp[2] = 7;
    for (int i = 0; i < 3; i++) begin rl[i] = 1'b1; rr[i] = 1'b0; end
    run_frame("short", 3, 1'b1, 1'b0);
    base = sv_cnt;
    send(1234, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    chk("stray_pulses", sv_cnt - base, 0);
    chk("stray_left", $signed(left_channel), 757);

    // Samples beyond NUM_CHANNELS are dropped
    pulse_start();
    for (int i = 0; i < 18; i++) send(1000, 1'b1, 1'b0, 1'b0);
    send(5000, 1'b1, 1'b1, 1'b1);
    chk("excess_sv", sample_valid, 1);
    chk("excess_left", $signed(left_channel), 18000);
    chk("excess_right", $signed(right_channel), 0);
    prev_l = 18000; prev_r = 0;

    // Overrun after 10 samples; the start-cycle valid is dropped
    pulse_start();
    for (int i = 0; i < 10; i++) send(500, 1'b1, 1'b1, 1'b0);
    sample_clk_en = 1'b1;
    send(9999, 1'b1, 1'b1, 1'b0);
    sample_clk_en = 1'b0;
    chk("ovr_pulse", frame_overrun, 1);
    chk("ovr_sv", sample_valid, 0);
    chk("ovr_left", $signed(left_channel), prev_l);
    chk("ovr_right", $signed(right_channel), prev_r);
    tick();
    chk("ovr_end", frame_overrun, 0);
    sl = 0; sr = 0;
    for (int i = 0; i < 18; i++) begin
      send(i * 10, 1'b1, i[0], 1'b0);
      sl += i * 10;
      if (i[0]) sr += i * 10;
    end
    expect_publish("after_ovr", sl, sr);

    // Back-to-back: start strobe lands in the SAT cycle
    pulse_start();
    send(400, 1'b1, 1'b0, 1'b0);
    send(-900, 1'b0, 1'b1, 1'b0);
    send(50, 1'b1, 1'b1, 1'b1);
    sample_clk_en = 1'b1;
    chk("b2b_sv_early", sample_valid, 0);
    tick();
    sample_clk_en = 1'b0;
    chk("b2b_sv", sample_valid, 1);
    chk("b2b_left", $signed(left_channel), 450);
    chk("b2b_right", $signed(right_channel), -850);
    send(-3, 1'b1, 1'b1, 1'b0);
    send(20, 1'b1, 1'b0, 1'b1);
    expect_publish("b2b_next", 17, -3);

    // Randomised frames against the reference sums
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++) begin
        smp[i] = int'($urandom_range(0, 65535)) - 32768;
        rl[i]  = 1'($urandom_range(0, 1));
        rr[i]  = 1'($urandom_range(0, 1));
      end
      run_frame("rand", n, (n < 18) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset in the middle of a frame
    pulse_start();
    for (int i = 0; i < 5; i++) send(1111, 1'b1, 1'b1, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_left", left_channel, 0);
    chk("mid_rst_right", right_channel, 0);
    chk("mid_rst_sv", sample_valid, 0);
    chk("mid_rst_clipL", clip_left, 0);
    chk("mid_rst_clipR", clip_right, 0);
    chk("mid_rst_ovr", frame_overrun, 0);
    tick();
    reset_n = 1'b1;
    base = sv_cnt;
    send(77, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    chk("mid_rst_pulses", sv_cnt - base, 0);
    smp[0] = 77; smp[1] = -7; rl[0] = 1'b1; rr[0] = 1'b0; rl[1] = 1'b1; rr[1] = 1'b1;
    run_frame("post_rst", 2, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
